// File: rtl/cache_refill_ctrl_if.sv
// Bundle of the miss-request, line word-mux, memory and line-buffer signals
// of cache_refill_ctrl; master = controller side, slave = environment side.
interface cache_refill_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
);
  logic              miss_valid;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_dirty;
  logic [ADDR_W-1:0] victim_addr;

  logic [IDX_W-1:0]  wb_sel;
  logic [DATA_W-1:0] wb_word;

  // Memory handshake: mem_req/mem_we/mem_addr/mem_wdata are held stable until a
  // cycle with mem_req && mem_ready, which transfers exactly one word; mem_ready
  // while mem_req is low carries no meaning. mem_rdata is valid on a read transfer.
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              fill_we;
  logic [IDX_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic              crit_valid;
  logic              busy;
  logic              done;

  modport master (
    input  miss_valid, miss_addr, miss_dirty, victim_addr, wb_word, mem_ready, mem_rdata,
    output wb_sel, mem_req, mem_we, mem_addr, mem_wdata,
           fill_we, fill_idx, fill_data, crit_valid, busy, done
  );

  modport slave (
    output miss_valid, miss_addr, miss_dirty, victim_addr, wb_word, mem_ready, mem_rdata,
    input  wb_sel, mem_req, mem_we, mem_addr, mem_wdata,
           fill_we, fill_idx, fill_data, crit_valid, busy, done
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Line refill sequencer: optional dirty-victim writeback, then an 8-word fill.
// Define CACHE_REFILL_CWF_EN to fill critical-word-first instead of from word 0.
module cache_refill_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_refill_ctrl_if.master bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  start_q, start_d;
  logic [ADDR_W-1:0] miss_base_q, miss_base_d;
  logic [ADDR_W-1:0] victim_base_q, victim_base_d;
  logic              fill_we_q, fill_we_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;

  logic [IDX_W-1:0]  start_eff;
  logic [IDX_W-1:0]  fill_pos;
  logic [IDX_W-1:0]  wb_sel;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  function automatic logic [ADDR_W-1:0] word_off(input logic [IDX_W-1:0] i);
    return {{(ADDR_W-IDX_W-2){1'b0}}, i, 2'b00};
  endfunction

`ifdef CACHE_REFILL_CWF_EN
  assign start_eff = start_q;
`else
  assign start_eff = '0;
`endif

  // IDX_W-bit add wraps modulo LINE_WORDS, so the fill never carries into the tag.
  assign fill_pos = start_eff + n_q;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    start_d       = start_q;
    miss_base_d   = miss_base_q;
    victim_base_d = victim_base_q;
    fill_we_d     = 1'b0;
    fill_idx_d    = '0;
    fill_data_d   = '0;
    wb_sel        = '0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.miss_valid) begin
          miss_base_d   = bus.miss_addr & LINE_MASK;
          victim_base_d = bus.victim_addr & LINE_MASK;
          start_d       = bus.miss_addr[IDX_W+1:2];
          n_d           = '0;
          state_d       = bus.miss_dirty ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        wb_sel    = n_q;
        mem_addr  = victim_base_q + word_off(n_q);
        mem_wdata = bus.wb_word;
        if (bus.mem_ready) begin
          n_d = n_q + 1'b1;
          if (n_q == LAST_IDX) state_d = S_FILL;
        end
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = miss_base_q + word_off(fill_pos);
        if (bus.mem_ready) begin
          fill_we_d   = 1'b1;
          fill_idx_d  = fill_pos;
          fill_data_d = bus.mem_rdata;
          n_d         = n_q + 1'b1;
          if (n_q == LAST_IDX) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      start_q       <= '0;
      miss_base_q   <= '0;
      victim_base_q <= '0;
      fill_we_q     <= 1'b0;
      fill_idx_q    <= '0;
      fill_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      start_q       <= start_d;
      miss_base_q   <= miss_base_d;
      victim_base_q <= victim_base_d;
      fill_we_q     <= fill_we_d;
      fill_idx_q    <= fill_idx_d;
      fill_data_q   <= fill_data_d;
    end
  end

  assign bus.wb_sel     = wb_sel;
  assign bus.mem_req    = mem_req;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.fill_we    = fill_we_q;
  assign bus.fill_idx   = fill_idx_q;
  assign bus.fill_data  = fill_data_q;
  // The requested word is the one whose line index equals the original miss offset.
  assign bus.crit_valid = fill_we_q && (fill_idx_q == start_q);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: a transfer/fill queue model checked every cycle,
// plus directed misses with hand-computed latencies, orders and crit positions.
module tb_cache_refill_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  cache_refill_ctrl_if bus ();

  cache_refill_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // Environment: idx-tagged victim words and an address-derived memory.
  assign bus.wb_word   = 32'hAB00_0000 | {29'd0, bus.wb_sel};
  assign bus.mem_rdata = 32'hC000_0000 ^ bus.mem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  int cyc        = 0;
  int ready_mode = 0;
  initial begin
    bus.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.mem_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  // ---------------- model + compare ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  sel;
  } xfer_t;
  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
  } fill_t;

  xfer_t       xq[$];
  fill_t       fq[$];
  logic        mbusy      = 1'b0;
  logic        pend       = 1'b0;
  logic [2:0]  m_start    = '0;
  int          acc_edge   = 0;
  int          done_edge  = 0;
  int          done_cnt   = 0;
  int          fill_cnt   = 0;
  int          crit_pos   = -1;
  logic [31:0] first_rd   = '0;
  logic        saw_rd     = 1'b0;

  task automatic model_accept(input logic [31:0] maddr, input logic dirty, input logic [31:0] vaddr);
    logic [31:0] mb, vb;
    logic [2:0]  s, s_eff, idx;
    mb = maddr & 32'hFFFF_FFE0;
    vb = vaddr & 32'hFFFF_FFE0;
    s  = maddr[4:2];
`ifdef CACHE_REFILL_CWF_EN
    s_eff = s;
`else
    s_eff = 3'd0;
`endif
    m_start = s;
    if (dirty)
      for (int w = 0; w < 8; w++)
        xq.push_back('{1'b1, vb + 32'(w * 4), 32'hAB00_0000 | 32'(w), 3'(w)});
    for (int k = 0; k < 8; k++) begin
      idx = 3'((int'(s_eff) + k) % 8);
      xq.push_back('{1'b0, mb + {27'd0, idx, 2'b00}, 32'd0, 3'd0});
      fq.push_back('{idx, 32'hC000_0000 ^ (mb + {27'd0, idx, 2'b00})});
    end
    fill_cnt = 0;
    crit_pos = -1;
    saw_rd   = 1'b0;
  endtask

  initial begin
    xfer_t f;
    fill_t fe;
    logic  pend_n, accept, exp_done;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        xq.delete();
        fq.delete();
        mbusy = 1'b0;
        pend  = 1'b0;
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_fill_we", {31'd0, bus.fill_we}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        continue;
      end
      pend_n = 1'b0;
      chk("busy", {31'd0, bus.busy}, {31'd0, mbusy});
      if (xq.size() > 0) begin
        f = xq[0];
        chk("mem_req", {31'd0, bus.mem_req}, 32'd1);
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, f.we});
        chk("mem_addr", bus.mem_addr, f.addr);
        if (f.we) chk("mem_wdata", bus.mem_wdata, f.wdata);
        chk("wb_sel", {29'd0, bus.wb_sel}, f.we ? {29'd0, f.sel} : 32'd0);
        if (bus.mem_ready) begin
          if (!f.we) begin
            pend_n = 1'b1;
            if (!saw_rd) first_rd = f.addr;
            saw_rd = 1'b1;
          end
          void'(xq.pop_front());
        end
      end else begin
        chk("mem_req_idle", {31'd0, bus.mem_req}, 32'd0);
        chk("wb_sel_idle", {29'd0, bus.wb_sel}, 32'd0);
      end
      chk("fill_we", {31'd0, bus.fill_we}, {31'd0, pend});
      if (pend && fq.size() > 0) begin
        fe = fq.pop_front();
        chk("fill_idx", {29'd0, bus.fill_idx}, {29'd0, fe.idx});
        chk("fill_data", bus.fill_data, fe.data);
        chk("crit_valid", {31'd0, bus.crit_valid}, {31'd0, fe.idx == m_start});
        if (bus.crit_valid) crit_pos = fill_cnt;
        fill_cnt++;
      end else begin
        chk("crit_idle", {31'd0, bus.crit_valid}, 32'd0);
      end
      pend     = pend_n;
      exp_done = mbusy && xq.size() == 0 && fq.size() == 0 && !pend;
      chk("done", {31'd0, bus.done}, {31'd0, exp_done});
      if (bus.done) done_cnt++;
      accept = !mbusy && bus.miss_valid;
      if (exp_done) begin
        mbusy     = 1'b0;
        done_edge = cyc + 1;
      end
      if (accept) begin
        model_accept(bus.miss_addr, bus.miss_dirty, bus.victim_addr);
        mbusy    = 1'b1;
        acc_edge = cyc + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits (bounded) for done seen at posedge+1, then lets the compare process settle.
  task automatic wait_done(output logic got);
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    #1;
  endtask

  // mode 0 normal, 1 pulse while busy, 2 pulse in DONE, 3 hold through done, 4 reset mid-fill
  task automatic do_miss(input logic [31:0] maddr, input logic dirty, input logic [31:0] vaddr,
                         input int mode, input int exp_lat);
    logic got;
    int   dc;
    dc = done_cnt;
    @(posedge clk);
    #1;
    bus.miss_addr   = maddr;
    bus.miss_dirty  = dirty;
    bus.victim_addr = vaddr;
    bus.miss_valid  = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    if (mode != 3) bus.miss_valid = 1'b0;
    if (mode == 4) begin
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("async_busy", {31'd0, bus.busy}, 32'd0);
      chk("async_fill_we", {31'd0, bus.fill_we}, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("no_done_after_rst", 32'(done_cnt), 32'(dc));
      chk("idle_after_rst", {30'd0, dbg_state}, 32'd0);
      return;
    end
    if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1;
      bus.miss_addr  = 32'hDEAD_0000;
      bus.miss_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.miss_valid = 1'b0;
    end
    wait_done(got);
    if (exp_lat > 0) chk("latency", 32'(done_edge - acc_edge), 32'(exp_lat));
    if (mode == 2) begin
      bus.miss_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.miss_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("done_pulse_ignored", {31'd0, bus.busy}, 32'd0);
    end
    if (mode == 3) begin
      @(posedge clk);
      #1;
      chk("held_idle_cycle", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      chk("held_reaccept", {31'd0, bus.busy}, 32'd1);
      bus.miss_valid = 1'b0;
      wait_done(got);
      chk("held_latency", 32'(done_edge - acc_edge), 32'd9);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int dc;
    rst_n           = 1'b0;
    bus.miss_valid  = 1'b0;
    bus.miss_addr   = '0;
    bus.miss_dirty  = 1'b0;
    bus.victim_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {30'd0, dbg_state}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    #1;
    rst_n = 1'b1;

    // Clean miss: fill 0x1040..0x105C, crit on the first fill, done at T0+9.
    do_miss(32'h0000_1040, 1'b0, 32'h0, 0, 9);
    chk("clean_first_rd", first_rd, 32'h0000_1040);
    chk("clean_crit_pos", 32'(crit_pos), 32'd0);
    chk("clean_fill_cnt", 32'(fill_cnt), 32'd8);

    // Dirty miss: writeback to 0x2000..0x201C then fill, done at T0+17.
    do_miss(32'h0000_5000, 1'b1, 32'h0000_2008, 0, 17);
    chk("dirty_fill_cnt", 32'(fill_cnt), 32'd8);

    // Miss on word 5 of line 0x3000.
    do_miss(32'h0000_3014, 1'b0, 32'h0, 0, 9);
`ifdef CACHE_REFILL_CWF_EN
    chk("cwf_first_rd", first_rd, 32'h0000_3014);
    chk("cwf_crit_pos", 32'(crit_pos), 32'd0);
`else
    chk("seq_first_rd", first_rd, 32'h0000_3000);
    chk("seq_crit_pos", 32'(crit_pos), 32'd5);
`endif

    // Throttled memory: ready every third cycle.
    ready_mode = 1;
    dc = done_cnt;
    do_miss(32'h0000_401C, 1'b1, 32'h0000_6004, 0, 0);
    chk("slow_fill_cnt", 32'(fill_cnt), 32'd8);
    repeat (4) @(posedge clk);
    #1;
    chk("slow_done_once", 32'(done_cnt - dc), 32'd1);
    ready_mode = 0;

    // Requests while busy and during DONE are dropped.
    do_miss(32'h0000_7000, 1'b0, 32'h0, 1, 9);
    do_miss(32'h0000_7020, 1'b1, 32'h0000_7F00, 2, 17);

    // Reset in the middle of a fill, then a clean restart.
    do_miss(32'h0000_8000, 1'b0, 32'h0, 4, 0);
    do_miss(32'h0000_9008, 1'b0, 32'h0, 0, 9);
    chk("restart_fill_cnt", 32'(fill_cnt), 32'd8);

    // miss_valid held through done is taken on the first IDLE cycle.
    do_miss(32'h0000_A00C, 1'b0, 32'h0, 3, 9);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
